// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit seven-segment scan scheduler with frame-synchronous load, message overlay and blink
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 128,
  parameter int MSG_FRAMES   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [19:0] data_in,
  input  logic        load,
  input  logic [19:0] msg_in,
  input  logic        msg_req,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  anode,
  output logic [4:0]  digit_code,
  output logic        frame_tick,
  output logic        msg_busy
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int MW = $clog2(MSG_FRAMES + 1);
  localparam logic [4:0] BLANK = 5'd17;
  localparam logic [19:0] BLANK4 = {4{BLANK}};
  typedef enum logic [1:0] {IDLE, ARMED, SHOW} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] slot_q, slot_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic blink_q, blink_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [19:0] disp_q, disp_d, pend_q, pend_d, msg_q, msg_d;
  logic pend_v_q, pend_v_d;
  logic [3:0] anode_d;
  logic [4:0] code_d;
  logic tc, bnd;
  always_comb begin
    tc = cnt_q == CW'(REFRESH_DIV - 1);
    bnd = tc && slot_q == 2'd3;
    cnt_d = tc ? '0 : cnt_q + 1'b1;
    slot_d = tc ? slot_q + 1'b1 : slot_q;
    bcnt_d = !bnd ? bcnt_q : (bcnt_q == BW'(BLINK_FRAMES - 1)) ? '0 : bcnt_q + 1'b1;
    blink_d = (bnd && bcnt_q == BW'(BLINK_FRAMES - 1)) ? ~blink_q : blink_q;
    // a load landing on the boundary itself bypasses pending and goes straight to display
    disp_d = bnd ? (load ? data_in : pend_v_q ? pend_q : disp_q) : disp_q;
    pend_d = (load && !bnd) ? data_in : pend_q;
    pend_v_d = bnd ? 1'b0 : (load | pend_v_q);
    state_d = state_q;
    mcnt_d = mcnt_q;
    msg_d = msg_q;
    case (state_q)
      IDLE: if (msg_req) begin
        state_d = ARMED;
        msg_d = msg_in;
      end
      ARMED: if (bnd) begin
        state_d = SHOW;
        mcnt_d = '0;
      end
      SHOW: if (bnd) begin
        state_d = (mcnt_q == MW'(MSG_FRAMES - 1)) ? IDLE : SHOW;
        mcnt_d = mcnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    anode_d = enable ? ~(4'b0001 << slot_q) : 4'b1111;
    code_d = !enable ? BLANK :
             state_q == SHOW ? msg_q[5*slot_q +: 5] :
             (blink_q && blink_mask[slot_q]) ? BLANK : disp_q[5*slot_q +: 5];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      slot_q <= '0;
      bcnt_q <= '0;
      blink_q <= 1'b0;
      mcnt_q <= '0;
      disp_q <= BLANK4;
      pend_q <= BLANK4;
      msg_q <= BLANK4;
      pend_v_q <= 1'b0;
      anode <= 4'b1111;
      digit_code <= BLANK;
      frame_tick <= 1'b0;
      msg_busy <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      slot_q <= slot_d;
      bcnt_q <= bcnt_d;
      blink_q <= blink_d;
      mcnt_q <= mcnt_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      msg_q <= msg_d;
      pend_v_q <= pend_v_d;
      anode <= anode_d;
      digit_code <= code_d;
      frame_tick <= bnd;
      msg_busy <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: table, directed and random checks of seg_scan_ctrl against a frame-level reference model
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic [19:0] data_in = '0;
  logic load = 1'b0;
  logic [19:0] msg_in = '0;
  logic msg_req = 1'b0;
  logic [3:0] blink_mask = '0;
  logic [3:0] anode;
  logic [4:0] digit_code;
  logic frame_tick, msg_busy;
  int errs = 0;
  int checks = 0;
  seg_scan_ctrl #(.REFRESH_DIV(4), .BLINK_FRAMES(2), .MSG_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in), .load(load),
    .msg_in(msg_in), .msg_req(msg_req), .blink_mask(blink_mask),
    .anode(anode), .digit_code(digit_code), .frame_tick(frame_tick), .msg_busy(msg_busy)
  );
  always #5 clk = ~clk;
  // model: k = edges since reset; slot, frame and blink phase follow from k by arithmetic
  int k = 0;
  logic [19:0] m_disp = {4{5'd17}};
  logic [19:0] p_data = '0;
  bit p_valid = 0;
  bit m_valid = 0;
  int m_start = 0;
  logic [19:0] m_msg = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
    end
  endtask
  task automatic step();
    int f, sl;
    bit bnd, show, busy_pre;
    logic [3:0] ea;
    logic [4:0] ec;
    logic et, eb;
    @(posedge clk);
    #1;
    if (rst) begin
      k = 0;
      m_disp = {4{5'd17}};
      p_valid = 0;
      m_valid = 0;
      ea = 4'hF; ec = 5'd17; et = 0; eb = 0;
    end else begin
      f = k / 16;
      sl = (k / 4) % 4;
      bnd = (k % 16) == 15;
      show = m_valid && f >= m_start && f < m_start + 3;
      busy_pre = m_valid && f < m_start + 3;
      ea = enable ? ~(4'b0001 << sl) : 4'hF;
      ec = !enable ? 5'd17 : show ? m_msg[5*sl +: 5] :
           (((f / 2) % 2 == 1) && blink_mask[sl]) ? 5'd17 : m_disp[5*sl +: 5];
      et = bnd;
      if (bnd) begin
        m_disp = load ? data_in : p_valid ? p_data : m_disp;
        p_valid = 0;
      end else if (load) begin
        p_data = data_in;
        p_valid = 1;
      end
      if (msg_req && !busy_pre) begin
        m_valid = 1;
        m_msg = msg_in;
        m_start = (k + 1) / 16 + 1;
      end
      k++;
      eb = m_valid && (k / 16) < m_start + 3;
    end
    chk("anode", 32'(anode), 32'(ea));
    chk("digit_code", 32'(digit_code), 32'(ec));
    chk("frame_tick", 32'(frame_tick), 32'(et));
    chk("msg_busy", 32'(msg_busy), 32'(eb));
  endtask
  task automatic wait_k(input int r);
    while (k % 16 != r) step();
  endtask
  typedef struct {
    int n;
    logic [3:0] an;
    logic [4:0] code;
    logic tick;
  } vec_t;
  vec_t tbl[9];
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{1, 4'b1110, 5'd17, 1'b0};
    tbl[1] = '{4, 4'b1110, 5'd17, 1'b0};
    tbl[2] = '{5, 4'b1101, 5'd17, 1'b0};
    tbl[3] = '{9, 4'b1011, 5'd17, 1'b0};
    tbl[4] = '{13, 4'b0111, 5'd17, 1'b0};
    tbl[5] = '{15, 4'b0111, 5'd17, 1'b0};
    tbl[6] = '{16, 4'b0111, 5'd17, 1'b1};
    tbl[7] = '{17, 4'b1110, 5'd17, 1'b0};
    tbl[8] = '{32, 4'b0111, 5'd17, 1'b1};
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      while (k < tbl[i].n) step();
      chk("tbl_anode", 32'(anode), 32'(tbl[i].an));
      chk("tbl_code", 32'(digit_code), 32'(tbl[i].code));
      chk("tbl_tick", 32'(frame_tick), 32'(tbl[i].tick));
    end
    // tear-free load with a second load winning
    wait_k(5);
    data_in = {5'd9, 5'd9, 5'd9, 5'd9};
    load = 1'b1;
    step();
    load = 1'b0;
    wait_k(9);
    data_in = {5'd4, 5'd3, 5'd2, 5'd1};
    load = 1'b1;
    step();
    load = 1'b0;
    wait_k(0);
    step();
    chk("load_first_code", 32'(digit_code), 32'd1);
    chk("load_first_anode", 32'(anode), 32'(4'b1110));
    // load exactly on the boundary cycle
    wait_k(15);
    data_in = {4{5'd8}};
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("bnd_load_code", 32'(digit_code), 32'd8);
    wait_k(15);
    data_in = {5'd4, 5'd3, 5'd2, 5'd1};
    load = 1'b1;
    step();
    load = 1'b0;
    // message overlay, ignored second request, resume
    wait_k(3);
    msg_in = {5'd18, 5'd19, 5'd20, 5'd21};
    msg_req = 1'b1;
    step();
    msg_req = 1'b0;
    chk("msg_busy_rise", 32'(msg_busy), 32'd1);
    wait_k(0);
    step();
    chk("msg_first_code", 32'(digit_code), 32'd21);
    wait_k(6);
    msg_in = {4{5'd9}};
    msg_req = 1'b1;
    step();
    msg_req = 1'b0;
    for (int i = 0; i < 200 && msg_busy; i++) step();
    chk("msg_end", 32'(msg_busy), 32'd0);
    step();
    chk("msg_resume_code", 32'(digit_code), 32'd1);
    chk("msg_resume_anode", 32'(anode), 32'(4'b1110));
    // blink alone, then blink under an overlay
    blink_mask = 4'b0101;
    for (int i = 0; i < 96; i++) step();
    msg_in = {4{5'd10}};
    msg_req = 1'b1;
    step();
    msg_req = 1'b0;
    for (int i = 0; i < 96; i++) step();
    blink_mask = 4'b0000;
    // enable off keeps the scan position
    wait_k(6);
    enable = 1'b0;
    step();
    chk("en_off_anode", 32'(anode), 32'hF);
    chk("en_off_code", 32'(digit_code), 32'd17);
    step();
    enable = 1'b1;
    step();
    chk("en_on_anode", 32'(anode), 32'(4'b1011));
    // reset while the overlay is showing
    wait_k(2);
    msg_req = 1'b1;
    step();
    msg_req = 1'b0;
    wait_k(0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_code", 32'(digit_code), 32'd17);
    chk("rst_busy", 32'(msg_busy), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(0, 7) == 0);
      data_in = 20'($urandom);
      msg_req = ($urandom_range(0, 39) == 0);
      msg_in = 20'($urandom);
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) blink_mask = 4'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scheduler for the shared 5-bit-code seven-segment decoder on the 4-digit display. It holds four 5-bit digit codes, scans one digit at a time, and drives the active-low anodes plus the decoder's code input. It adds tear-free frame-synchronous updates, a timed status-message overlay (e.g. OPEn/CLSd) and per-digit blinking.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range >=2
BLINK_FRAMES, 128, full scan frames per blink half-period; legal range >=1
MSG_FRAMES, 1000, frames a requested message stays displayed; legal range >=1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  1 = display active; 0 = all digits off
data_in  in  20  normal codes; [4:0]=digit0 (rightmost) .. [19:15]=digit3
load  in  1  1-cycle strobe: capture data_in into the pending buffer
msg_in  in  20  overlay message codes, same packing as data_in
msg_req  in  1  1-cycle strobe: request message overlay
blink_mask  in  4  bit i = blink digit i
anode  out  4  active-low digit enables, bit i = digit i
digit_code  out  5  code to the seven-segment decoder
frame_tick  out  1  1-cycle pulse at each frame wrap
msg_busy  out  1  overlay pending or active

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All outputs registered.
- Reset values: anode=4'b1111, digit_code=5'd17 (blank), frame_tick=0, msg_busy=0. Display regs, pending regs and message regs = 17 each. Pending valid=0, slot=0, refresh count=0, blink phase=0, message frame count=0.
- Refresh counter: 0..REFRESH_DIV-1, free-running while not in reset (also runs when enable=0). At terminal count:
  - it wraps to 0;
  - slot advances 0->1->2->3->0.
- Frame boundary = terminal count with slot=3. frame_tick goes high the cycle after the boundary edge, for exactly 1 cycle.
- Output pipeline: anode/digit_code reflect the slot register with 1-cycle latency. The first anode change after reset is 4'b1110, one cycle after rst deasserts.
- anode = ~(4'b0001 << slot). Only one digit is low at a time; the block never drives two digits low.
- Code selection for the current slot, in priority order:
  1. enable=0: anode=1111, code=17.
  2. Overlay active: message code of the slot.
  3. blink phase=1 and blink_mask[slot]=1: code 17, anode still driven.
  4. Otherwise: display code of the slot.
- load:
  - captures data_in into pending and sets pending valid.
  - At the next frame boundary, pending is copied to display and valid is cleared.
  - A later load before the boundary overwrites pending (last wins).
  - load on the boundary cycle itself: data_in is written directly to display and valid is cleared.
- Message FSM, states IDLE/ARMED/SHOW:
  - IDLE + msg_req: capture msg_in, msg_busy=1, go to ARMED.
  - ARMED + frame boundary: go to SHOW, count=0. The overlay is visible from slot 0 of the next frame.
  - SHOW: count increments on each frame boundary. At count=MSG_FRAMES-1 on a boundary, go to IDLE and set msg_busy=0; normal display resumes at the next frame's slot 0.
  - msg_req in ARMED or SHOW is ignored; no queueing and no restart.
  - msg_req on the same cycle as an ARMED->SHOW boundary is also ignored.
- Blink phase toggles every BLINK_FRAMES frame boundaries. It runs continuously, independent of mask, enable or overlay.
- Overlay and load are independent. A load during SHOW updates display, which becomes visible after the overlay ends.
- rst mid-frame or mid-message returns everything to reset values on the next edge. Pending loads and messages are discarded.
- Codes are passed through unchecked. Values 28-31 reach the decoder as-is.

Test Plan:
- Bench params: REFRESH_DIV=4, BLINK_FRAMES=2, MSG_FRAMES=3.
- Reset/scan: release rst, enable=1, no load -> anode cycles 1110,1101,1011,0111 for 4 clks each; digit_code=17 throughout; frame_tick pulses every 16 clks.
- Tear-free load: load data_in={5'd4,5'd3,5'd2,5'd1} mid-frame at slot 1 -> the rest of that frame still shows 17. The next frame shows codes 1,2,3,4 on anode 1110,1101,1011,0111. A second load before the boundary wins.
- Boundary load: assert load on the exact slot-3 terminal cycle with data_in=all 5'd8 -> the next frame shows 8 on every digit.
- Message: display=1,2,3,4; msg_req with msg_in={5'd18,5'd19,5'd20,5'd21} (OPEn) -> msg_busy=1 next cycle. OPEn shows for exactly 3 frames from the next boundary; a msg_req during SHOW is ignored; msg_busy falls and 1,2,3,4 returns.
- Blink: blink_mask=4'b0101 -> digits 0 and 2 show code 17 for 2 frames, then their codes for 2 frames, repeating. Digits 1 and 3 are unaffected. Blink is suppressed during an overlay.
- Enable/reset: enable=0 mid-scan -> anode=1111, code=17 next cycle, scan position preserved. rst during SHOW -> outputs return to reset values next edge and msg_busy=0.
